nibble_serial_addsub: RTL and testbench

//  Multi-nibble add/subtract engine built around one 4-bit add/sub datapath.

---
 rtl/nibble_serial_addsub_pkg.sv | 20 ++
 rtl/nibble_serial_addsub_nibble.sv | 27 ++
 rtl/nibble_serial_addsub.sv | 134 +++++++++++++
 tb/tb_nibble_serial_addsub.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_addsub_pkg.sv
// Shared constants and types for the nibble-serial add/subtract engine.
// Mode encodings, nibble width, FSM state codes and an index-width helper.
package nibble_serial_addsub_pkg;

    localparam logic MODE_SUM   = 1'b0;
    localparam logic MODE_MINUS = 1'b1;
    localparam int   NIBBLE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Nibble counter width; a single-nibble engine still needs a 1-bit index.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_addsub_nibble.sv
// Combinational 4-bit add/subtract slice (module addsub_nibble).
// Exposes the carry into bit 3 so the caller can derive signed overflow.
module addsub_nibble
    import nibble_serial_addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                mode,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                c3,
    output logic                cout
);

    logic [NIBBLE_W-1:0] b_eff_s;
    logic [3:0]          low_s;
    logic [1:0]          top_s;

    assign b_eff_s = (mode == MODE_SUM) ? b : ~b;
    // Split at bit 3 so the carry into the MSB is visible on its own.
    assign low_s   = {1'b0, a[2:0]} + {1'b0, b_eff_s[2:0]} + {3'b000, cin};
    assign top_s   = {1'b0, a[3]} + {1'b0, b_eff_s[3]} + {1'b0, low_s[3]};
    assign sum     = {top_s[0], low_s[2:0]};
    assign c3      = low_s[3];
    assign cout    = top_s[1];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-nibble add/subtract engine: one nibble per clock, LSB first,
// with carry chained through a register and start/busy/done handshake.
module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic [4*NIBBLES-1:0]    a,
    input  logic [4*NIBBLES-1:0]    b,
    output logic                    busy,
    output logic                    done,
    output logic [4*NIBBLES-1:0]    result,
    output logic                    cout,
    output logic                    overflow
);

    localparam int                W        = NIBBLE_W * NIBBLES;
    localparam int                IDX_W    = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               mode_q, mode_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [W-1:0]       result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] nib_a_s;
    logic [NIBBLE_W-1:0] nib_b_s;
    logic [NIBBLE_W-1:0] nib_sum_s;
    logic                nib_c3_s;
    logic                nib_cout_s;

    assign nib_a_s = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign nib_b_s = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

    addsub_nibble u_nibble (
        .a    (nib_a_s),
        .b    (nib_b_s),
        .mode (mode_q),
        .cin  (carry_q),
        .sum  (nib_sum_s),
        .c3   (nib_c3_s),
        .cout (nib_cout_s)
    );

    // Next-state, datapath and completion logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    // Subtraction is a + ~b + 1: the +1 enters as the first carry.
                    carry_d = mode;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_sum_s;
                carry_d = nib_cout_s;
                if (idx_q == LAST_IDX) begin
                    result_d = acc_d;
                    cout_d   = nib_cout_s;
                    ovf_d    = nib_c3_s ^ nib_cout_s;
                    idx_d    = {IDX_W{1'b0}};
                    state_d  = ST_DONE;
                end else begin
                    idx_d    = idx_q + IDX_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= {IDX_W{1'b0}};
            carry_q  <= 1'b0;
            mode_q   <= 1'b0;
            a_q      <= {W{1'b0}};
            b_q      <= {W{1'b0}};
            acc_q    <= {W{1'b0}};
            result_q <= {W{1'b0}};
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub (NIBBLES=4): directed cases
// plus random operations against a plain-arithmetic reference model.
module tb_nibble_serial_addsub;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int tests;
    int fails;

    logic [W-1:0] hold_res;
    logic         hold_cout;
    logic         hold_ovf;

    nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_edge;
        @(posedge clk);
        #1;
    endtask

    // Issue start with the given operands; returns just after the start edge.
    task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb, input logic lm);
        start = 1'b1;
        a     = la;
        b     = lb;
        mode  = lm;
        do_edge();
        start = 1'b0;
    endtask

    // Runs the remaining NIBBLES edges of an operation and checks the outcome.
    task automatic complete(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic em,
                            input bit hold, input string tag);
        logic [W:0]   full;
        logic [W-1:0] er;
        logic         ec;
        logic         eo;
        full = {1'b0, ea} + {1'b0, (em ? ~eb : eb)} + {{W{1'b0}}, em};
        er   = full[W-1:0];
        ec   = full[W];
        if (em) eo = (ea[W-1] != eb[W-1]) && (er[W-1] != ea[W-1]);
        else    eo = (ea[W-1] == eb[W-1]) && (er[W-1] != ea[W-1]);
        for (int k = 0; k < NIBBLES; k++) begin
            check({tag, "_busy"}, 64'(busy), 64'(1'b1));
            check({tag, "_done_early"}, 64'(done), 64'(1'b0));
            check({tag, "_hold"}, 64'({cout, overflow, result}), 64'({hold_cout, hold_ovf, hold_res}));
            start = hold;
            a     = W'($urandom);
            b     = W'($urandom);
            mode  = 1'($urandom_range(0, 1));
            do_edge();
        end
        start = 1'b0;
        check({tag, "_done"}, 64'(done), 64'(1'b1));
        check({tag, "_busy_off"}, 64'(busy), 64'(1'b0));
        check({tag, "_result"}, 64'(result), 64'(er));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        check({tag, "_ovf"}, 64'(overflow), 64'(eo));
        hold_res  = er;
        hold_cout = ec;
        hold_ovf  = eo;
    endtask

    task automatic idle_cycle(input string tag);
        start = 1'b0;
        do_edge();
        check({tag, "_idle_busy"}, 64'(busy), 64'(1'b0));
        check({tag, "_idle_done"}, 64'(done), 64'(1'b0));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rm;
        tests     = 0;
        fails     = 0;
        hold_res  = '0;
        hold_cout = 1'b0;
        hold_ovf  = 1'b0;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a     = '0;
        b     = '0;

        #2;
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_done", 64'(done), 64'(1'b0));
        check("rst_outs", 64'({cout, overflow, result}), 64'(0));
        do_edge();
        do_edge();
        rst = 1'b0;
        idle_cycle("init");

        launch(16'h1234, 16'h0FFF, 1'b0);
        complete(16'h1234, 16'h0FFF, 1'b0, 1'b0, "t1_sum");
        idle_cycle("t1");
        launch(16'h0003, 16'h0008, 1'b1);
        complete(16'h0003, 16'h0008, 1'b1, 1'b0, "t2_minus");
        idle_cycle("t2");
        launch(16'h7FFF, 16'h0001, 1'b0);
        complete(16'h7FFF, 16'h0001, 1'b0, 1'b0, "t3_sumovf");
        idle_cycle("t3");
        launch(16'h8000, 16'h0001, 1'b1);
        complete(16'h8000, 16'h0001, 1'b1, 1'b0, "t4_minusovf");
        idle_cycle("t4");

        // start held through RUN, then accepted in the DONE cycle
        launch(16'h1111, 16'h2222, 1'b0);
        complete(16'h1111, 16'h2222, 1'b0, 1'b1, "t5_hold");
        launch(16'h00FF, 16'h0F01, 1'b1);
        complete(16'h00FF, 16'h0F01, 1'b1, 1'b0, "t5_b2b");
        idle_cycle("t5");

        // asynchronous reset two clocks into an operation
        launch(16'h1234, 16'h4321, 1'b0);
        do_edge();
        do_edge();
        rst = 1'b1;
        #1;
        check("t6_rst_busy", 64'(busy), 64'(1'b0));
        check("t6_rst_done", 64'(done), 64'(1'b0));
        check("t6_rst_outs", 64'({cout, overflow, result}), 64'(0));
        hold_res  = '0;
        hold_cout = 1'b0;
        hold_ovf  = 1'b0;
        do_edge();
        rst = 1'b0;
        idle_cycle("t6");
        launch(16'h0001, 16'h0001, 1'b0);
        complete(16'h0001, 16'h0001, 1'b0, 1'b0, "t6_after");

        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rm = 1'($urandom_range(0, 1));
            if (i % 6 == 0) ra = {1'b0, {(W-1){1'b1}}};
            if (i % 6 == 3) rb = {1'b1, {(W-1){1'b0}}};
            if ($urandom_range(0, 1) == 1) idle_cycle("rnd");
            launch(ra, rb, rm);
            complete(ra, rb, rm, 1'($urandom_range(0, 1)), "rnd");
        end
        idle_cycle("end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
